// File: rtl/ex_fsm_sd_pkg.sv
// Shared constants for the 1-0-0-1 serial sequence detector: state encodings and pattern.
package ex_fsm_sd_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned PAT_W   = 4;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_S1    = 3'd1;
  localparam state_t ST_S10   = 3'd2;
  localparam state_t ST_S100  = 3'd3;
  localparam state_t ST_S1001 = 3'd4;

  // Pattern bits are consumed MSB first.
  localparam logic [PAT_W-1:0] PATTERN = 4'b1001;

endpackage

// File: rtl/ex_fsm_sd_core.sv
// Moore detector for serial pattern 1-0-0-1 on cin with overlapping matches;
// cout is a registered one-cycle flag held while the state is S1001.
module ex_fsm_sd_core
  import ex_fsm_sd_pkg::*;
(
  input  logic sclk,
  input  logic rst_n,
  input  logic cin,
  output logic cout
);

  state_t r_state;
  state_t w_next;
  logic   r_cout;

  // Next-state: each state advances on the next expected pattern bit, else
  // falls back to the longest suffix that is still a pattern prefix.
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next = (cin == PATTERN[3]) ? ST_S1    : ST_IDLE;
      ST_S1:    w_next = (cin == PATTERN[2]) ? ST_S10   : ST_S1;
      ST_S10:   w_next = (cin == PATTERN[1]) ? ST_S100  : ST_S1;
      ST_S100:  w_next = (cin == PATTERN[0]) ? ST_S1001 : ST_IDLE;
      ST_S1001: w_next = (cin == PATTERN[2]) ? ST_S10   : ST_S1;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register; rst_n is an active-high synchronous reset despite its name.
  always_ff @(posedge sclk) begin
    if (rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Output decoded from the next state so the flag lines up with r_state == S1001.
  always_ff @(posedge sclk) begin
    if (rst_n) begin
      r_cout <= 1'b0;
    end else begin
      r_cout <= (w_next == ST_S1001);
    end
  end

  assign cout = r_cout;

endmodule

// File: tb/tb_ex_fsm_sd_core.sv
// Directed and random checks for the 1-0-0-1 sequence detector.
module tb_ex_fsm_sd_core;
  import ex_fsm_sd_pkg::*;

  logic sclk;
  logic rst_n;
  logic cin;
  logic cout;

  int n_checks;
  int n_fail;
  logic [3:0] sr_model;

  ex_fsm_sd_core u_dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .cin   (cin),
    .cout  (cout)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one bit at the falling edge, then sample just after the rising edge.
  task automatic step(input logic b);
    @(negedge sclk);
    cin = b;
    @(posedge sclk);
    #1;
  endtask

  // Bits are applied MSB first; exp holds the hand-derived cout after each edge.
  task automatic apply(input string tag, input int n, input logic [31:0] bits,
                       input logic [31:0] exp);
    logic [31:0] vb;
    logic [31:0] ve;
    vb = bits;
    ve = exp;
    for (int i = 0; i < n; i++) begin
      step(vb[n-1-i]);
      check($sformatf("%s[%0d]", tag, i), 32'(cout), 32'(ve[n-1-i]));
    end
  endtask

  task automatic do_reset(input string tag, input int cycles);
    @(negedge sclk);
    rst_n = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      step(1'(i % 2));
      check($sformatf("%s_cout[%0d]", tag, i), 32'(cout), 32'd0);
    end
    @(negedge sclk);
    rst_n = 1'b0;
    sr_model = 4'b0000;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sr_model = 4'b0000;
    rst_n    = 1'b1;
    cin      = 1'b0;

    // Reset held for 5 edges with cin toggling.
    do_reset("rst", 5);
    check("rst_state", 32'(u_dut.r_state), 32'(ST_IDLE));

    // 0,0,1,0,0,1 then 1,1,1: single pulse right after the final '1'.
    apply("basic", 9, 32'b001001111, 32'b000001000);

    // 1,0,1,0,1: no match.
    apply("nomatch", 5, 32'b10101, 32'b00000);

    // 1,0,0,1,0,0,1: overlapping matches, pulses three cycles apart.
    apply("overlap", 7, 32'b1001001, 32'b0001001);

    // 1,0,0 then a single reset edge, then 1: partial match is discarded.
    apply("midpre", 3, 32'b100, 32'b000);
    do_reset("midrst", 1);
    apply("midpost", 5, 32'b11001, 32'b00001);

    // Random stream against a shift-register reference.
    do_reset("rndrst", 2);
    for (int i = 0; i < 1000; i++) begin
      logic b;
      b = 1'($urandom_range(1, 0));
      step(b);
      sr_model = {sr_model[2:0], b};
      check($sformatf("rnd[%0d]", i), 32'(cout), 32'(sr_model == 4'b1001));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_fsm_sd_core.md
EX_FSM_SD_CORE -- requirements
Module: ex_fsm_sd

Interface
REQ-001 Parameters: none; the detected pattern is fixed at 4'b1001, first bit first.
REQ-002 sclk  input  1  sole clock; all state updates occur on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-high; rst_n=1 at a rising sclk edge resets the block. The port name is historical; the polarity is fixed as stated.
REQ-004 cin  input  1  serial data bit, one bit sampled per rising sclk edge.
REQ-005 cout  output  1  detection flag, registered, one cycle wide per detected pattern.

Function
REQ-006 The block SHALL be a Moore FSM detecting serial sequence 1-0-0-1 on cin, overlapping detections allowed.
REQ-007 States: IDLE (no prefix), S1 ("1"), S10 ("10"), S100 ("100"), S1001 (match).
REQ-008 Transitions from IDLE: cin=1 -> S1; cin=0 -> IDLE.
REQ-009 Transitions from S1: cin=1 -> S1; cin=0 -> S10.
REQ-010 Transitions from S10: cin=1 -> S1; cin=0 -> S100.
REQ-011 Transitions from S100: cin=1 -> S1001; cin=0 -> IDLE.
REQ-012 Transitions from S1001 (overlap; trailing "1" reused): cin=1 -> S1; cin=0 -> S10.
REQ-013 cout SHALL be 1 exactly while the state register holds S1001, and 0 otherwise.
REQ-014 Latency: cout rises in the clock cycle immediately after the edge that samples the final '1'.
REQ-015 cout SHALL last exactly one cycle per match, even if cin stays 1 afterwards.
REQ-016 Back-to-back overlapping matches SHALL each produce a pulse; 1001001 gives two pulses three cycles apart.
REQ-017 Unused or illegal state encodings SHALL return to IDLE on the next edge, with cout=0.
REQ-018 cout SHALL have no combinational path from cin.

Reset
REQ-019 While rst_n=1 at a rising edge: state <= IDLE and cout <= 0, irrespective of cin.
REQ-020 Reset SHALL discard any partial match. The first bit sampled after reset deasserts starts a fresh search.
REQ-021 No asynchronous reset path SHALL exist. Before the first reset edge, outputs are don't-care.

Structure
REQ-022 State encodings (5 states, 3-bit binary) SHALL be localparams in a shared package ex_fsm_sd_pkg, together with the pattern constant 4'b1001.
REQ-023 The block SHALL be a single module with no sub-modules.
REQ-024 It SHALL contain one registered state process, one combinational next-state process, and a registered output decode.

Verification
REQ-025 Reset then idle: rst_n=1 for 5 cycles with cin toggling -> cout=0 throughout; state=IDLE after release.
REQ-026 Basic match: after reset, cin=0,0,1,0,0,1 then held at 1 -> exactly one cout pulse, in the cycle after the final '1' is sampled; no further pulses while cin stays 1.
REQ-027 Non-match: cin=1,0,1,0,1 -> cout stays 0.
REQ-028 Overlap: cin=1,0,0,1,0,0,1 -> two one-cycle cout pulses, three cycles apart.
REQ-029 Reset mid-sequence: cin=1,0,0, then rst_n=1 for one edge, then cin=1 -> cout=0; a later full 1,0,0,1 -> one pulse.
REQ-030 Random check: 1000 random cin bits compared against a 4-bit shift-register reference model (pulse when the last 4 bits = 1001, delayed one cycle) -> zero mismatches.
